// File: rtl/n64_drive_mixer_pkg.sv
// Shared constants, state encoding and stick/command helpers for the N64 drive mixer.
package n64_pkg;

  localparam int BIT_A     = 0;
  localparam int BIT_B     = 1;
  localparam int BIT_Z     = 2;
  localparam int BIT_START = 3;
  localparam int BIT_RSV0  = 8;
  localparam int BIT_RSV1  = 9;
  localparam int X_MSB     = 16;
  localparam int Y_MSB     = 24;
  localparam int CMD_W     = 8;

  typedef enum logic [1:0] {
    ST_LINK_DOWN = 2'd0,
    ST_ACQUIRE   = 2'd1,
    ST_LINK_UP   = 2'd2
  } link_state_t;

  typedef logic signed [CMD_W-1:0] cmd_t;

  // The stick bytes arrive MSB first, so the first received bit lands in bit 7.
  function automatic logic [7:0] stick_field(input logic [31:0] rep, input int msb);
    logic [7:0] f;
    f = 8'd0;
    for (int i = 0; i < 8; i++) begin
      f[7-i] = rep[msb+i];
    end
    return f;
  endfunction

  function automatic cmd_t apply_deadzone(input cmd_t v, input int dz);
    cmd_t v1;
    int   m;
    v1 = (v == 8'sh80) ? 8'sh81 : v;
    m  = (v1 < 8'sd0) ? -int'(v1) : int'(v1);
    if (m <= dz) begin
      return 8'sd0;
    end else begin
      return v1;
    end
  endfunction

  function automatic cmd_t sat_cmd(input logic signed [9:0] s);
    if (s > 10'sd127) begin
      return 8'sd127;
    end else if (s < -10'sd127) begin
      return 8'sh81;
    end else begin
      return s[7:0];
    end
  endfunction

  function automatic logic [6:0] cmd_mag(input cmd_t c);
    cmd_t n;
    if (c[7]) begin
      n = -c;
    end else begin
      n = c;
    end
    return n[6:0];
  endfunction

endpackage

// File: rtl/n64_drive_mixer_if.sv
// Report strobe bus from the controller poller into the drive mixer.
interface n64_drive_mixer_if;
  logic [31:0] report;
  logic        report_valid;

  modport master (output report, output report_valid);
  modport slave  (input report, input report_valid);
endinterface

// File: rtl/n64_drive_mixer_pwm.sv
// One motor channel: 127-step PWM with wrap-synchronous duty updates and an immediate kill.
module n64_pwm_channel #(
  parameter int PWM_DIV = 4
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic [6:0] cmd_mag,
  input  logic       cmd_dir,
  input  logic       force_off,
  output logic       pwm,
  output logic       dir
);

  localparam logic [7:0] DIV_LAST  = 8'(PWM_DIV - 1);
  localparam logic [6:0] STEP_LAST = 7'd126;

  logic [7:0] pres_r, pres_nxt_s;
  logic [6:0] step_r, step_nxt_s;
  logic [6:0] act_r, act_nxt_s;
  logic       dir_r, dir_nxt_s;
  logic       pwm_r, pwm_nxt_s;
  logic       step_tick_s, wrap_s;

  // Next-state for prescaler, step counter and active duty.
  always_comb begin
    step_tick_s = (pres_r == DIV_LAST);
    wrap_s      = step_tick_s && (step_r == STEP_LAST);
    if (step_tick_s) begin
      pres_nxt_s = 8'd0;
      step_nxt_s = (step_r == STEP_LAST) ? 7'd0 : step_r + 7'd1;
    end else begin
      pres_nxt_s = pres_r + 8'd1;
      step_nxt_s = step_r;
    end
    // A kill must not wait for the period to finish; new duty otherwise waits for wrap.
    if (force_off) begin
      act_nxt_s = 7'd0;
      dir_nxt_s = 1'b0;
    end else if (wrap_s) begin
      act_nxt_s = cmd_mag;
      dir_nxt_s = cmd_dir;
    end else begin
      act_nxt_s = act_r;
      dir_nxt_s = dir_r;
    end
    pwm_nxt_s = (step_nxt_s < act_nxt_s);
  end

  // Channel state registers.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      pres_r <= 8'd0;
      step_r <= 7'd0;
      act_r  <= 7'd0;
      dir_r  <= 1'b0;
      pwm_r  <= 1'b0;
    end else begin
      pres_r <= pres_nxt_s;
      step_r <= step_nxt_s;
      act_r  <= act_nxt_s;
      dir_r  <= dir_nxt_s;
      pwm_r  <= pwm_nxt_s;
    end
  end

  assign pwm = pwm_r;
  assign dir = dir_r;

endmodule

// File: rtl/n64_drive_mixer.sv
// Report filter, link FSM with timeout, deadzone and arcade mixer driving two PWM channels.
module n64_drive_mixer
  import n64_pkg::*;
#(
  parameter int STABLE_REPORTS = 3,
  parameter int TIMEOUT_TICKS  = 1_250_000,
  parameter int DEADZONE       = 8,
  parameter int PWM_DIV        = 4
) (
  input  logic                    PCLK,
  input  logic                    RESET,
  n64_drive_mixer_if.slave        rpt,
  output logic [15:0]             buttons,
  output logic [7:0]              joy_x,
  output logic [7:0]              joy_y,
  output logic                    link_up,
  output logic                    pwm_left,
  output logic                    pwm_right,
  output logic                    dir_left,
  output logic                    dir_right
);

  localparam int                  TIMER_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_V = TIMER_W'(TIMEOUT_TICKS);
  localparam logic [TIMER_W-1:0]  TIMER_ONE = TIMER_W'(1);
  localparam logic [3:0]          STABLE_V  = 4'(STABLE_REPORTS);

  link_state_t          state_r;
  logic [31:0]          cand_r;
  logic [3:0]           count_r, count_nxt_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [15:0]          buttons_r;
  logic [7:0]           joy_x_r, joy_y_r;
  logic                 link_up_r;
  logic                 good_s, accept_s, timeout_s;

  cmd_t                 x_dz_s, y_dz_s, left_cmd_s, right_cmd_s;
  logic signed [9:0]    left_sum_s, right_sum_s;
  logic [6:0]           mag_l_r, mag_r_r;
  logic                 cdir_l_r, cdir_r_r;
  logic                 force_off_s;

  // Report qualification and stability counting.
  always_comb begin
    good_s = rpt.report_valid & ~rpt.report[BIT_RSV0] & ~rpt.report[BIT_RSV1];
    if (rpt.report == cand_r) begin
      if (count_r >= STABLE_V) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + 4'd1;
      end
    end else begin
      count_nxt_s = 4'd1;
    end
    accept_s  = good_s & (count_nxt_s == STABLE_V);
    timeout_s = ~good_s & (state_r != ST_LINK_DOWN) & (timer_r == TIMEOUT_V);
  end

  // Link FSM with registered accepted outputs; a valid report beats a coincident timeout.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_LINK_DOWN;
      cand_r    <= 32'd0;
      count_r   <= 4'd0;
      timer_r   <= '0;
      buttons_r <= 16'd0;
      joy_x_r   <= 8'd0;
      joy_y_r   <= 8'd0;
      link_up_r <= 1'b0;
    end else if (good_s) begin
      cand_r  <= rpt.report;
      count_r <= count_nxt_s;
      timer_r <= '0;
      if (accept_s) begin
        state_r   <= ST_LINK_UP;
        link_up_r <= 1'b1;
        buttons_r <= rpt.report[15:0];
        joy_x_r   <= stick_field(rpt.report, X_MSB);
        joy_y_r   <= stick_field(rpt.report, Y_MSB);
      end else if (state_r == ST_LINK_DOWN) begin
        state_r <= ST_ACQUIRE;
      end else begin
        state_r <= state_r;
      end
    end else if (timeout_s) begin
      // Forget the candidate so reacquisition needs a fresh run of identical reports.
      state_r   <= ST_LINK_DOWN;
      cand_r    <= 32'd0;
      count_r   <= 4'd0;
      timer_r   <= '0;
      buttons_r <= 16'd0;
      joy_x_r   <= 8'd0;
      joy_y_r   <= 8'd0;
      link_up_r <= 1'b0;
    end else if ((state_r != ST_LINK_DOWN) && (timer_r != TIMEOUT_V)) begin
      timer_r <= timer_r + TIMER_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Deadzone, arcade mix and dead-man gating.
  always_comb begin
    x_dz_s      = apply_deadzone(cmd_t'(joy_x_r), DEADZONE);
    y_dz_s      = apply_deadzone(cmd_t'(joy_y_r), DEADZONE);
    left_sum_s  = {{2{y_dz_s[7]}}, y_dz_s} + {{2{x_dz_s[7]}}, x_dz_s};
    right_sum_s = {{2{y_dz_s[7]}}, y_dz_s} - {{2{x_dz_s[7]}}, x_dz_s};
    if (buttons_r[BIT_Z]) begin
      left_cmd_s  = sat_cmd(left_sum_s);
      right_cmd_s = sat_cmd(right_sum_s);
    end else begin
      left_cmd_s  = 8'sd0;
      right_cmd_s = 8'sd0;
    end
  end

  // Pending motor commands, one cycle behind the accepted stick values.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      mag_l_r  <= 7'd0;
      mag_r_r  <= 7'd0;
      cdir_l_r <= 1'b0;
      cdir_r_r <= 1'b0;
    end else begin
      mag_l_r  <= cmd_mag(left_cmd_s);
      mag_r_r  <= cmd_mag(right_cmd_s);
      cdir_l_r <= left_cmd_s[7];
      cdir_r_r <= right_cmd_s[7];
    end
  end

  assign force_off_s = ~link_up_r | ~buttons_r[BIT_Z];

  n64_pwm_channel #(.PWM_DIV(PWM_DIV)) u_pwm_left (
    .PCLK      (PCLK),
    .RESET     (RESET),
    .cmd_mag   (mag_l_r),
    .cmd_dir   (cdir_l_r),
    .force_off (force_off_s),
    .pwm       (pwm_left),
    .dir       (dir_left)
  );

  n64_pwm_channel #(.PWM_DIV(PWM_DIV)) u_pwm_right (
    .PCLK      (PCLK),
    .RESET     (RESET),
    .cmd_mag   (mag_r_r),
    .cmd_dir   (cdir_r_r),
    .force_off (force_off_s),
    .pwm       (pwm_right),
    .dir       (dir_right)
  );

  assign buttons = buttons_r;
  assign joy_x   = joy_x_r;
  assign joy_y   = joy_y_r;
  assign link_up = link_up_r;

endmodule

// File: tb/tb_n64_drive_mixer.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor pops and compares.
module tb_n64_drive_mixer;

  localparam int DIV = 2;
  localparam int TMO = 400;
  localparam int P   = 127 * DIV;
  localparam int K_STATE = 0, K_PWM = 1, K_PWML = 2, K_DUTY = 3;

  logic        PCLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] buttons;
  logic [7:0]  joy_x, joy_y;
  logic        link_up, pwm_left, pwm_right, dir_left, dir_right;

  n64_drive_mixer_if bus();

  n64_drive_mixer #(
    .STABLE_REPORTS(3), .TIMEOUT_TICKS(TMO), .DEADZONE(8), .PWM_DIV(DIV)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .rpt(bus),
    .buttons(buttons), .joy_x(joy_x), .joy_y(joy_y), .link_up(link_up),
    .pwm_left(pwm_left), .pwm_right(pwm_right), .dir_left(dir_left), .dir_right(dir_right)
  );

  typedef struct {
    int    cyc;
    int    kind;
    string nm;
    int    a, b, c, d;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   r0 = 0;
  bit   hl[P];
  bit   hr[P];
  int   suml = 0, sumr = 0, hidx = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: sliding one-period high counts plus cycle-stamped scoreboard compares.
  always @(negedge PCLK) begin
    suml = suml + int'(pwm_left) - int'(hl[hidx]);
    sumr = sumr + int'(pwm_right) - int'(hr[hidx]);
    hl[hidx] = pwm_left;
    hr[hidx] = pwm_right;
    hidx = (hidx + 1) % P;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) chk({mon_e.nm, ".late"}, cyc, mon_e.cyc);
      case (mon_e.kind)
        K_STATE: begin
          chk({mon_e.nm, ".link_up"}, int'(link_up), mon_e.a);
          chk({mon_e.nm, ".buttons"}, int'(buttons), mon_e.b);
          chk({mon_e.nm, ".joy_x"},   int'(joy_x),   mon_e.c);
          chk({mon_e.nm, ".joy_y"},   int'(joy_y),   mon_e.d);
        end
        K_PWM: begin
          chk({mon_e.nm, ".pwm_left"},  int'(pwm_left),  mon_e.a);
          chk({mon_e.nm, ".pwm_right"}, int'(pwm_right), mon_e.b);
          chk({mon_e.nm, ".dir_left"},  int'(dir_left),  mon_e.c);
          chk({mon_e.nm, ".dir_right"}, int'(dir_right), mon_e.d);
        end
        K_PWML: chk({mon_e.nm, ".pwm_left"}, int'(pwm_left), mon_e.a);
        default: begin
          chk({mon_e.nm, ".duty_left"},  suml, mon_e.a);
          chk({mon_e.nm, ".duty_right"}, sumr, mon_e.b);
          chk({mon_e.nm, ".dir_left"},   int'(dir_left),  mon_e.c);
          chk({mon_e.nm, ".dir_right"},  int'(dir_right), mon_e.d);
        end
      endcase
    end
  end

  task automatic push(input string nm, input int c, input int kind,
                      input int a, input int b, input int cc, input int d);
    exp_t e;
    int   pos;
    e.cyc = c; e.kind = kind; e.nm = nm; e.a = a; e.b = b; e.c = cc; e.d = d;
    pos = q.size();
    while (pos > 0 && q[pos-1].cyc > c) pos--;
    q.insert(pos, e);
  endtask

  function automatic logic [31:0] mk(input logic [15:0] btn, input logic [7:0] x, input logic [7:0] y);
    logic [31:0] r;
    r = {16'd0, btn};
    for (int i = 0; i < 8; i++) begin
      r[16+i] = x[7-i];
      r[24+i] = y[7-i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic strobe(input logic [31:0] r);
    bus.report = r;
    bus.report_valid = 1'b1;
    tick();
    bus.report_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 20 == 0) strobe(r);
      else tick();
    end
  endtask

  // Settle on one report, then check accepted values and per-period high counts.
  task automatic phase(input string nm, input logic [15:0] btn, input logic [7:0] x, input logic [7:0] y,
                       input int dl, input int dr, input int sl, input int sr);
    run(mk(btn, x, y), 600);
    push({nm, ".state"}, cyc + 1, K_STATE, 1, int'(btn), int'(x), int'(y));
    push({nm, ".duty"},  cyc + 1, K_DUTY, dl, dr, sl, sr);
    tick();
  endtask

  logic [31:0] r1, r_z90, r_nz, r_bad;
  int s;
  int guard;

  initial begin
    bus.report = 32'd0;
    bus.report_valid = 1'b0;
    r1    = mk(16'h0004, 8'd0, 8'd100);
    r_z90 = mk(16'h0004, 8'd0, 8'd90);
    r_nz  = mk(16'h0000, 8'd0, 8'd90);
    r_bad = r_z90 | 32'h0000_0100;

    repeat (5) tick();
    RESET = 1'b0;
    r0 = cyc + 1;
    repeat (3) tick();
    push("reset", cyc + 1, K_STATE, 0, 0, 0, 0);
    push("reset", cyc + 1, K_PWM, 0, 0, 0, 0);
    tick();

    // Acquisition: two identical reports keep the link down, the third locks it.
    push("acq1", cyc + 1, K_STATE, 0, 0, 0, 0);
    strobe(r1);
    repeat (9) tick();
    push("acq2", cyc + 1, K_STATE, 0, 0, 0, 0);
    strobe(r1);
    repeat (9) tick();
    push("lock", cyc + 1, K_STATE, 1, 4, 0, 100);
    strobe(r1);

    phase("y100",    16'h0004, 8'd0,   8'd100, 100 * DIV, 100 * DIV, 0, 0);
    phase("y100x60", 16'h0004, 8'd60,  8'd100, 127 * DIV, 40 * DIV,  0, 0);
    phase("xdead",   16'h0004, 8'hFB,  8'd100, 100 * DIV, 100 * DIV, 0, 0);

    // A single glitched report (A pressed) must never be accepted.
    for (int i = 0; i < 5; i++) begin
      push($sformatf("glitch%0d", i), cyc + 1, K_STATE, 1, 4, 8'hFB, 100);
      strobe((i == 1) ? (mk(16'h0004, 8'hFB, 8'd100) | 32'h1) : mk(16'h0004, 8'hFB, 8'd100));
      repeat (9) tick();
    end

    phase("rev",  16'h0004, 8'd0,  8'h9C, 100 * DIV, 100 * DIV, 1, 1);
    phase("spin", 16'h0004, 8'd50, 8'd0,  50 * DIV,  50 * DIV,  0, 1);
    phase("z90",  16'h0004, 8'd0,  8'd90, 90 * DIV,  90 * DIV,  0, 0);

    // Z release lands early in a period: pwm high one cycle, then killed without waiting for wrap.
    strobe(r_nz);
    repeat (9) tick();
    strobe(r_nz);
    while (((cyc - r0 + 3) % P) != 20 * DIV) tick();
    push("zrel_pre",   cyc + 1, K_PWM, 1, 1, 0, 0);
    push("zrel_state", cyc + 1, K_STATE, 1, 0, 0, 90);
    push("zrel_kill",  cyc + 2, K_PWM, 0, 0, 0, 0);
    strobe(r_nz);
    run(r_nz, 100);
    push("zrel_hold", cyc + 1, K_PWM, 0, 0, 0, 0);
    tick();
    phase("zpress", 16'h0004, 8'd0, 8'd90, 90 * DIV, 90 * DIV, 0, 0);

    // Report arriving exactly when the timer reaches the limit keeps the link.
    s = cyc;
    strobe(r_z90);
    while (cyc < s + 1 + TMO) tick();
    push("coinc_a", cyc + 1, K_STATE, 1, 4, 0, 90);
    push("coinc_b", cyc + 2, K_STATE, 1, 4, 0, 90);
    strobe(r_z90);
    repeat (3) tick();

    // Only malformed reports after the last good one: link drops at the timeout.
    s = cyc;
    strobe(r_z90);
    push("tmo_before", s + TMO + 1, K_STATE, 1, 4, 0, 90);
    push("tmo_drop",   s + TMO + 2, K_STATE, 0, 0, 0, 0);
    push("tmo_pwm",    s + TMO + 3, K_PWM, 0, 0, 0, 0);
    while (cyc < s + TMO + 5) begin
      if ((cyc - s) % 10 == 0) strobe(r_bad);
      else tick();
    end

    // Relink with left saturated, then reset mid-period.
    phase("relink", 16'h0004, 8'd60, 8'd100, 127 * DIV, 40 * DIV, 0, 0);
    push("pre_reset", cyc + 1, K_PWML, 1, 0, 0, 0);
    tick();
    tick();
    RESET = 1'b1;
    push("async_reset", cyc, K_STATE, 0, 0, 0, 0);
    push("async_reset", cyc, K_PWM, 0, 0, 0, 0);
    repeat (3) tick();
    RESET = 1'b0;
    repeat (3) tick();

    guard = 0;
    while (q.size() > 0 && guard < 1000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never reached, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
